// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
//   Hazard controller for a short in-order pipeline. Detects load-use
//   hazards between the decode-stage load and the fetch-stage sources.
//   Stalls for multi-cycle execute ops. Converts taken branches into
//   fetch/decode flushes.
//
//   Parameters
//     REG_AW      register-address width
//     NSRC        source operands compared per fetched instruction
//     LU_BUBBLES  bubbles per load-use hazard (1..7)
//     MC_LAT      execute latency of a multi-cycle op (2..15)
//
//   Ports
//     clk, rst_n        clock, async active-low reset
//     branch_taken      branch resolved taken in execute
//     mem_read_dec      decode instruction is a load
//     mc_op_dec         decode instruction is multi-cycle
//     rdst_dec          decode destination register
//     rsrc_fetch        fetch sources, source i at [i*REG_AW +: REG_AW]
//     rsrc_vld_fetch    per-source valid
//     flush_fetch/flush_decode  squash fetch/decode, clear decode/execute
//     stall_fetch/stall_decode  hold fetch/decode, decode/execute regs
//     pc_write          PC update enable
//     busy              a stall sequence is in progress
//     stall_cnt/flush_cnt  saturating perf counters (HAZARD_PERF_CNT_EN only)
//
//   Optional feature macro: HAZARD_PERF_CNT_EN
module pipeline_hazard_unit #(
    parameter int REG_AW     = 3,
    parameter int NSRC       = 2,
    parameter int LU_BUBBLES = 1,
    parameter int MC_LAT     = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   branch_taken,
    input  logic                   mem_read_dec,
    input  logic                   mc_op_dec,
    input  logic [REG_AW-1:0]      rdst_dec,
    input  logic [NSRC*REG_AW-1:0] rsrc_fetch,
    input  logic [NSRC-1:0]        rsrc_vld_fetch,
    output logic                   flush_fetch,
    output logic                   flush_decode,
    output logic                   stall_fetch,
    output logic                   stall_decode,
    output logic                   pc_write,
`ifdef HAZARD_PERF_CNT_EN
    output logic [15:0]            stall_cnt,
    output logic [15:0]            flush_cnt,
`endif
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, LU_STALL, MC_STALL} state_e;

    // The first stall cycle is spent in IDLE, and the exit cycle sees cnt==0.
    // For that reason each counter starts at its total length minus 2.
    localparam logic [3:0] LU_INIT = 4'(LU_BUBBLES - 2);
    localparam logic [3:0] MC_INIT = 4'(MC_LAT - 2);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pend_flush_q, pend_flush_d;

    // Only a clean 1 counts as asserted. X or Z falls through as deasserted.
    logic br_a, mr_a, mc_a;
    assign br_a = (branch_taken === 1'b1);
    assign mr_a = (mem_read_dec === 1'b1);
    assign mc_a = (mc_op_dec === 1'b1);

    logic src_match, hit;
    always_comb begin
        src_match = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if ((rsrc_vld_fetch[i] === 1'b1) &&
                (rsrc_fetch[i*REG_AW +: REG_AW] == rdst_dec))
                src_match = 1'b1;
        end
        hit = mr_a && src_match;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_flush_d = pend_flush_q;
        flush_fetch  = 1'b0;
        flush_decode = 1'b0;
        stall_fetch  = 1'b0;
        stall_decode = 1'b0;
        pc_write     = 1'b1;
        case (state_q)
            IDLE: begin
                if (pend_flush_q) begin
                    // A branch resolved during an MC stall is applied here.
                    // Any new hazard seen in this cycle is squashed with it.
                    flush_fetch  = 1'b1;
                    flush_decode = 1'b1;
                    pend_flush_d = 1'b0;
                end else if (br_a) begin
                    flush_fetch  = 1'b1;
                    flush_decode = 1'b1;
                end else if (hit) begin
                    flush_decode = 1'b1;
                    stall_fetch  = 1'b1;
                    pc_write     = 1'b0;
                    if (LU_BUBBLES > 1) begin
                        state_d = LU_STALL;
                        cnt_d   = LU_INIT;
                    end
                end else if (mc_a) begin
                    state_d = MC_STALL;
                    cnt_d   = MC_INIT;
                end
            end
            LU_STALL: begin
                if (br_a) begin
                    flush_fetch  = 1'b1;
                    flush_decode = 1'b1;
                    state_d      = IDLE;
                    cnt_d        = 4'd0;
                end else begin
                    flush_decode = 1'b1;
                    stall_fetch  = 1'b1;
                    pc_write     = 1'b0;
                    if (cnt_q == 4'd0) state_d = IDLE;
                    else               cnt_d   = cnt_q - 4'd1;
                end
            end
            MC_STALL: begin
                // The op in execute must complete. A branch is only remembered here.
                stall_fetch  = 1'b1;
                stall_decode = 1'b1;
                pc_write     = 1'b0;
                if (br_a) pend_flush_d = 1'b1;
                if (cnt_q == 4'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            pend_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_flush_q <= pend_flush_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (stall_fetch && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush_fetch && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Testbench for pipeline_hazard_unit.
// Two instances share the same inputs:
//   dut1  LU_BUBBLES=1, MC_LAT=4
//   dut3  LU_BUBBLES=3, MC_LAT=4
// Output vectors are packed as {flush_fetch, flush_decode, stall_fetch,
// stall_decode, pc_write, busy}.
module tb_pipeline_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       branch_taken, mem_read_dec, mc_op_dec;
    logic [2:0] rdst_dec;
    logic [5:0] rsrc_fetch;
    logic [1:0] rsrc_vld_fetch;

    logic ff1, fd1, sf1, sd1, pw1, bz1;
    logic ff3, fd3, sf3, sd3, pw3, bz3;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] scnt1, fcnt1, scnt3, fcnt3;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_unit #(.REG_AW(3), .NSRC(2), .LU_BUBBLES(1), .MC_LAT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken),
        .mem_read_dec(mem_read_dec), .mc_op_dec(mc_op_dec), .rdst_dec(rdst_dec),
        .rsrc_fetch(rsrc_fetch), .rsrc_vld_fetch(rsrc_vld_fetch),
        .flush_fetch(ff1), .flush_decode(fd1), .stall_fetch(sf1),
        .stall_decode(sd1), .pc_write(pw1),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt(scnt1), .flush_cnt(fcnt1),
`endif
        .busy(bz1));

    pipeline_hazard_unit #(.REG_AW(3), .NSRC(2), .LU_BUBBLES(3), .MC_LAT(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken),
        .mem_read_dec(mem_read_dec), .mc_op_dec(mc_op_dec), .rdst_dec(rdst_dec),
        .rsrc_fetch(rsrc_fetch), .rsrc_vld_fetch(rsrc_vld_fetch),
        .flush_fetch(ff3), .flush_decode(fd3), .stall_fetch(sf3),
        .stall_decode(sd3), .pc_write(pw3),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt(scnt3), .flush_cnt(fcnt3),
`endif
        .busy(bz3));

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [5:0] o1();
        return {ff1, fd1, sf1, sd1, pw1, bz1};
    endfunction
    function automatic logic [5:0] o3();
        return {ff3, fd3, sf3, sd3, pw3, bz3};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic br, input logic mr, input logic mc,
                         input logic [2:0] rd, input logic [5:0] rs, input logic [1:0] vl);
        branch_taken   = br;
        mem_read_dec   = mr;
        mc_op_dec      = mc;
        rdst_dec       = rd;
        rsrc_fetch     = rs;
        rsrc_vld_fetch = vl;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 6'd0, 2'b00);
    endtask

    // Inputs are driven at posedge+1. Outputs are checked at the following negedge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_in();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    typedef struct {
        string      name;
        logic       br;
        logic       mr;
        logic [2:0] rd;
        logic [5:0] rs;
        logic [1:0] vl;
        logic [5:0] exp;
    } vec_t;

    function automatic vec_t mk(input string n, input logic br, input logic mr,
                                input logic [2:0] rd, input logic [5:0] rs,
                                input logic [1:0] vl, input logic [5:0] exp);
        vec_t v;
        v.name = n; v.br = br; v.mr = mr; v.rd = rd; v.rs = rs; v.vl = vl; v.exp = exp;
        return v;
    endfunction

    vec_t vecs[10];

    initial begin
        // Only single-cycle behaviour of dut1 (LU_BUBBLES=1) is checked here.
        //                name          br    mr    rd    {s1,s0}     vld    {ff fd sf sd pw bz}
        vecs[0] = mk("idle",        1'b0, 1'b0, 3'd0, 6'o00, 2'b00, 6'b000010);
        vecs[1] = mk("lu_hit_s1",   1'b0, 1'b1, 3'd3, 6'o30, 2'b10, 6'b011000);
        vecs[2] = mk("lu_s1_inval", 1'b0, 1'b1, 3'd3, 6'o30, 2'b01, 6'b000010);
        vecs[3] = mk("lu_mr_x",     1'b0, 1'bx, 3'd3, 6'o30, 2'b10, 6'b000010);
        vecs[4] = mk("lu_hit_s0",   1'b0, 1'b1, 3'd3, 6'o03, 2'b01, 6'b011000);
        vecs[5] = mk("no_load",     1'b0, 1'b0, 3'd3, 6'o33, 2'b11, 6'b000010);
        vecs[6] = mk("branch",      1'b1, 1'b0, 3'd0, 6'o00, 2'b00, 6'b110010);
        vecs[7] = mk("branch_hit",  1'b1, 1'b1, 3'd3, 6'o33, 2'b11, 6'b110010);
        vecs[8] = mk("lu_hit_r7",   1'b0, 1'b1, 3'd7, 6'o77, 2'b11, 6'b011000);
        vecs[9] = mk("lu_nomatch",  1'b0, 1'b1, 3'd5, 6'o46, 2'b11, 6'b000010);

        // Reset state: apply reset asynchronously, before any clock edge.
        rst_n = 1'b0;
        idle_in();
        #3;
        chk("reset_dut1", 16'(o1()), 16'(6'b000010));
        chk("reset_dut3", 16'(o3()), 16'(6'b000010));
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].br, vecs[i].mr, 1'b0, vecs[i].rd, vecs[i].rs, vecs[i].vl);
            @(negedge clk);
            chk(vecs[i].name, 16'(o1()), 16'(vecs[i].exp));
            next_cycle();
        end

        // dut3: a full load-use hold lasts exactly 3 cycles.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 3'd3, 6'o30, 2'b10);
        @(negedge clk); chk("lu3_c0", 16'(o3()), 16'(6'b011000));
        next_cycle(); idle_in();
        @(negedge clk); chk("lu3_c1", 16'(o3()), 16'(6'b011001));
        next_cycle();
        @(negedge clk); chk("lu3_c2", 16'(o3()), 16'(6'b011001));
        next_cycle();
        @(negedge clk); chk("lu3_c3", 16'(o3()), 16'(6'b000010));
        next_cycle();

        // dut3: a branch in the 2nd stall cycle aborts the load-use stall.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 3'd3, 6'o30, 2'b10);
        @(negedge clk); chk("lu3br_c0", 16'(o3()), 16'(6'b011000));
        next_cycle(); drive(1'b1, 1'b0, 1'b0, 3'd0, 6'd0, 2'b00);
        @(negedge clk); chk("lu3br_c1", 16'(o3()), 16'(6'b110011));
        next_cycle(); idle_in();
        @(negedge clk); chk("lu3br_c2", 16'(o3()), 16'(6'b000010));
        next_cycle();

        // dut1: MC_LAT=4 gives 3 stall cycles. A branch in the 2nd cycle is flushed in the first IDLE cycle.
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 3'd0, 6'd0, 2'b00);
        @(negedge clk); chk("mc_c0", 16'(o1()), 16'(6'b000010));
        next_cycle(); idle_in();
        @(negedge clk); chk("mc_c1", 16'(o1()), 16'(6'b001101));
        next_cycle(); branch_taken = 1'b1;
        @(negedge clk); chk("mc_c2_br", 16'(o1()), 16'(6'b001101));
        next_cycle(); idle_in();
        @(negedge clk); chk("mc_c3", 16'(o1()), 16'(6'b001101));
        // The mc op and the load-use hit seen in the pending-flush cycle must not take effect.
        next_cycle(); drive(1'b0, 1'b1, 1'b1, 3'd3, 6'o30, 2'b10);
        @(negedge clk); chk("mc_c4_pflush", 16'(o1()), 16'(6'b110010));
        next_cycle(); idle_in();
        @(negedge clk); chk("mc_c5_idle", 16'(o1()), 16'(6'b000010));
        next_cycle();

        // dut1: a reset in the middle of MC_STALL aborts the stall immediately.
        do_reset();
        mc_op_dec = 1'b1;
        next_cycle(); idle_in();
        @(negedge clk); chk("mcrst_stall", 16'(o1()), 16'(6'b001101));
        #2 rst_n = 1'b0;
        #1 chk("mcrst_abort", 16'(o1()), 16'(6'b000010));
`ifdef HAZARD_PERF_CNT_EN
        chk("mcrst_scnt", scnt1, 16'd0);
`endif
        next_cycle(); rst_n = 1'b1;
        @(negedge clk); chk("mcrst_after", 16'(o1()), 16'(6'b000010));
        next_cycle();

`ifdef HAZARD_PERF_CNT_EN
        // dut1 counters: one load-use stall cycle, then one branch flush cycle.
        drive(1'b0, 1'b1, 1'b0, 3'd3, 6'o30, 2'b10);
        next_cycle(); drive(1'b1, 1'b0, 1'b0, 3'd0, 6'd0, 2'b00);
        next_cycle(); idle_in();
        @(negedge clk);
        chk("perf_scnt", scnt1, 16'd1);
        chk("perf_fcnt", fcnt1, 16'd1);
        next_cycle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
